// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter and access sequencer for the
// single-cycle data memory. Port 0 is the CPU load/store path, port 1 the
// debug/loader path. Requests are checked for legality before any memory
// access, and all memory-side and requester-side outputs are registered.
module dmem_arbiter #(
  parameter int ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        rst_n,       // active-high synchronous reset
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [2:0]  p0_type,
  input  logic [31:0] p0_wdata,
  output logic        p0_ack,
  output logic        p0_err,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [2:0]  p1_type,
  input  logic [31:0] p1_wdata,
  output logic        p1_ack,
  output logic        p1_err,
  output logic [31:0] p1_rdata,
  output logic        mem_W_en,
  output logic        mem_R_en,
  output logic [31:0] mem_addr,
  output logic [2:0]  mem_RW_type,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // A request is illegal on an unknown type, a store with an unsigned-load
  // type, a misaligned half/word, or an address beyond the backed memory.
  function automatic logic is_illegal(input logic we, input logic [31:0] addr,
                                      input logic [2:0] typ);
    logic bad;
    case (typ)
      3'b000:  bad = 1'b0;
      3'b001:  bad = addr[0];
      3'b010:  bad = (addr[1:0] != 2'b00);
      3'b100:  bad = we;
      3'b101:  bad = we | addr[0];
      default: bad = 1'b1;
    endcase
    bad = bad | ((addr >> ADDR_BITS) != 32'd0);
    return bad;
  endfunction

  state_t      state_r, next_state_s;
  logic        last_grant_r;
  logic        gnt_r;
  logic        we_r;
  logic [31:0] addr_r;
  logic [2:0]  type_r;
  logic [31:0] wdata_r;
  logic        err_r;

  logic        p0_ack_r, p1_ack_r, p0_err_r, p1_err_r;
  logic [31:0] p0_rdata_r, p1_rdata_r;
  logic        mem_w_en_r, mem_r_en_r;
  logic [31:0] mem_addr_r, mem_din_r;
  logic [2:0]  mem_type_r;
  logic        busy_r;

  logic        gnt_s;
  logic        sel_we_s;
  logic [31:0] sel_addr_s;
  logic [2:0]  sel_type_s;
  logic [31:0] sel_wdata_s;
  logic        illegal_s;
  logic        resp_gnt_s;
  logic        resp_err_s;

  // Round-robin grant, request selection and legality of the selected request.
  always_comb begin
    gnt_s = 1'b0;
    if (p0_req && p1_req) begin
      gnt_s = ~last_grant_r;
    end else if (p1_req) begin
      gnt_s = 1'b1;
    end else begin
      gnt_s = 1'b0;
    end
    sel_we_s    = gnt_s ? p1_we    : p0_we;
    sel_addr_s  = gnt_s ? p1_addr  : p0_addr;
    sel_type_s  = gnt_s ? p1_type  : p0_type;
    sel_wdata_s = gnt_s ? p1_wdata : p0_wdata;
    illegal_s   = is_illegal(sel_we_s, sel_addr_s, sel_type_s);
    // Owner and error flag of the transaction entering RESP on this edge.
    if (state_r == IDLE) begin
      resp_gnt_s = gnt_s;
      resp_err_s = illegal_s;
    end else begin
      resp_gnt_s = gnt_r;
      resp_err_s = err_r;
    end
  end

  // Next-state logic: illegal requests skip ACCESS and go straight to RESP.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (p0_req || p1_req) begin
          if (illegal_s) begin
            next_state_s = RESP;
          end else begin
            next_state_s = ACCESS;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      ACCESS:  next_state_s = RESP;
      RESP:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Latch the granted request and its legality when leaving IDLE; update
  // the round-robin pointer when the transaction completes.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      last_grant_r <= 1'b1;
      gnt_r        <= 1'b0;
      we_r         <= 1'b0;
      addr_r       <= 32'd0;
      type_r       <= 3'd0;
      wdata_r      <= 32'd0;
      err_r        <= 1'b0;
    end else begin
      if (state_r == IDLE && (p0_req || p1_req)) begin
        gnt_r   <= gnt_s;
        we_r    <= sel_we_s;
        addr_r  <= sel_addr_s;
        type_r  <= sel_type_s;
        wdata_r <= sel_wdata_s;
        err_r   <= illegal_s;
      end
      if (state_r == RESP) begin
        last_grant_r <= gnt_r;
      end
    end
  end

  // Memory-side outputs: loaded on entry to ACCESS so they are live for
  // exactly the ACCESS cycle and zero otherwise.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      mem_w_en_r <= 1'b0;
      mem_r_en_r <= 1'b0;
      mem_addr_r <= 32'd0;
      mem_type_r <= 3'd0;
      mem_din_r  <= 32'd0;
    end else if (next_state_s == ACCESS) begin
      mem_w_en_r <= sel_we_s;
      mem_r_en_r <= ~sel_we_s;
      mem_addr_r <= sel_addr_s;
      mem_type_r <= sel_type_s;
      mem_din_r  <= sel_wdata_s;
    end else begin
      mem_w_en_r <= 1'b0;
      mem_r_en_r <= 1'b0;
      mem_addr_r <= 32'd0;
      mem_type_r <= 3'd0;
      mem_din_r  <= 32'd0;
    end
  end

  // Completion pulse and error flag, raised for the owner on entry to RESP.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      p0_ack_r <= 1'b0;
      p1_ack_r <= 1'b0;
      p0_err_r <= 1'b0;
      p1_err_r <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      p0_ack_r <= (next_state_s == RESP) & ~resp_gnt_s;
      p1_ack_r <= (next_state_s == RESP) &  resp_gnt_s;
      p0_err_r <= (next_state_s == RESP) & ~resp_gnt_s & resp_err_s;
      p1_err_r <= (next_state_s == RESP) &  resp_gnt_s & resp_err_s;
      busy_r   <= (next_state_s != IDLE);
    end
  end

  // Load data capture at the end of ACCESS; held until the next load.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      p0_rdata_r <= 32'd0;
      p1_rdata_r <= 32'd0;
    end else if (state_r == ACCESS && !we_r) begin
      if (gnt_r) begin
        p1_rdata_r <= mem_dout;
      end else begin
        p0_rdata_r <= mem_dout;
      end
    end
  end

  assign p0_ack      = p0_ack_r;
  assign p1_ack      = p1_ack_r;
  assign p0_err      = p0_err_r;
  assign p1_err      = p1_err_r;
  assign p0_rdata    = p0_rdata_r;
  assign p1_rdata    = p1_rdata_r;
  assign mem_W_en    = mem_w_en_r;
  assign mem_R_en    = mem_r_en_r;
  assign mem_addr    = mem_addr_r;
  assign mem_RW_type = mem_type_r;
  assign mem_din     = mem_din_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: behavioural memory, per-port scoreboard queues
// filled by the drivers and drained by an ack monitor, plus latency checks.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic [2:0]  p0_type, p1_type;
  logic        p0_ack, p0_err, p1_ack, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_W_en, mem_R_en;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic [2:0]  mem_RW_type;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int we_cnt = 0;
  int re_cnt = 0;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] last_rd [2];
  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_BITS(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_type(p0_type),
    .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_type(p1_type),
    .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_W_en(mem_W_en), .mem_R_en(mem_R_en), .mem_addr(mem_addr),
    .mem_RW_type(mem_RW_type), .mem_din(mem_din), .mem_dout(mem_dout),
    .busy(busy)
  );

  // Little-endian memory read with extension by access type.
  function automatic logic [31:0] ld_ext(input logic [31:0] w, input logic [1:0] off,
                                         input logic [2:0] t);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*off +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (t)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'd0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  assign mem_dout = ld_ext(mem[mem_addr[9:2]], mem_addr[1:0], mem_RW_type);

  // Memory write port.
  always @(posedge clk) begin
    if (mem_W_en) begin
      case (mem_RW_type)
        3'b000:  mem[mem_addr[9:2]][8*mem_addr[1:0] +: 8] <= mem_din[7:0];
        3'b001:  mem[mem_addr[9:2]][16*mem_addr[1] +: 16] <= mem_din[15:0];
        default: mem[mem_addr[9:2]] <= mem_din;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Ack monitor: pops the owner's scoreboard entry and compares err/rdata.
  always @(negedge clk) begin
    exp_t e;
    if (mem_W_en) we_cnt++;
    if (mem_R_en) re_cnt++;
    if (p0_ack || p1_ack) chk("mem_quiet_at_ack", {30'd0, mem_W_en, mem_R_en}, 32'd0);
    if (p0_ack) begin
      if (q0.size() == 0) begin
        chk("p0_spurious_ack", 32'd1, 32'd0);
      end else begin
        e = q0.pop_front();
        chk("p0_err", 32'(p0_err), 32'(e.err));
        chk("p0_rdata", p0_rdata, e.rdata);
      end
    end
    if (p1_ack) begin
      if (q1.size() == 0) begin
        chk("p1_spurious_ack", 32'd1, 32'd0);
      end else begin
        e = q1.pop_front();
        chk("p1_err", 32'(p1_err), 32'(e.err));
        chk("p1_rdata", p1_rdata, e.rdata);
      end
    end
  end

  task automatic drive(input int port, input logic req, input logic we,
                       input logic [31:0] addr, input logic [2:0] t, input logic [31:0] wd);
    if (port == 0) begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_type = t; p0_wdata = wd;
    end else begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_type = t; p1_wdata = wd;
    end
  endtask

  // Expected rdata: stores and errored requests leave the port's rdata alone.
  task automatic push(input int port, input logic we, input logic err, input logic [31:0] ld_val);
    exp_t e;
    e.err   = err;
    e.rdata = (err || we) ? last_rd[port] : ld_val;
    last_rd[port] = e.rdata;
    if (port == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    q0.delete();
    q1.delete();
  endtask

  // One request on one port; checks ack latency and memory enable counts.
  task automatic xfer(input string tag, input int port, input logic we, input logic [31:0] addr,
                      input logic [2:0] t, input logic [31:0] wd, input logic err,
                      input logic [31:0] ld_val);
    int   w0, r0, cyc;
    logic got;
    @(negedge clk);
    w0 = we_cnt;
    r0 = re_cnt;
    push(port, we, err, ld_val);
    drive(port, 1'b1, we, addr, t, wd);
    @(posedge clk);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 12) begin
      @(negedge clk);
      cyc++;
      got = (port == 0) ? p0_ack : p1_ack;
    end
    chk({tag, "_lat"}, 32'(cyc), err ? 32'd1 : 32'd2);
    drive(port, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
    chk({tag, "_wen"}, 32'(we_cnt - w0), (!err && we) ? 32'd1 : 32'd0);
    chk({tag, "_ren"}, 32'(re_cnt - r0), (!err && !we) ? 32'd1 : 32'd0);
  endtask

  // Tie right after reset: p0 wins, p0 re-requests at once and must lose to p1.
  task automatic dual(input logic [31:0] a0, input logic [31:0] e0, input logic [31:0] a1,
                      input logic [31:0] e1, input logic [31:0] a0b, input logic [31:0] e0b);
    int c0a, c0b, c1, cyc;
    c0a = 0; c0b = 0; c1 = 0; cyc = 0;
    @(negedge clk);
    push(0, 1'b0, 1'b0, e0);
    push(1, 1'b0, 1'b0, e1);
    drive(0, 1'b1, 1'b0, a0, 3'b010, 32'd0);
    drive(1, 1'b1, 1'b0, a1, 3'b010, 32'd0);
    @(posedge clk);
    while ((c0b == 0 || c1 == 0) && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (p0_ack) begin
        if (c0a == 0) begin
          c0a = cyc;
          push(0, 1'b0, 1'b0, e0b);
          drive(0, 1'b1, 1'b0, a0b, 3'b010, 32'd0);
        end else begin
          c0b = cyc;
          drive(0, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
        end
      end
      if (p1_ack) begin
        c1 = cyc;
        drive(1, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
      end
    end
    chk("tie_p0_first", 32'(c0a), 32'd2);
    chk("tie_p1_second", 32'(c1), 32'd5);
    chk("tie_p0_again", 32'(c0b), 32'd8);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    rst_n = 1'b1;
    drive(0, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
    do_reset();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", {30'd0, p0_ack, p1_ack}, 32'd0);
    chk("rst_err", {30'd0, p0_err, p1_err}, 32'd0);
    chk("rst_p0_rdata", p0_rdata, 32'd0);
    chk("rst_p1_rdata", p1_rdata, 32'd0);
    chk("rst_mem_en", {30'd0, mem_W_en, mem_R_en}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);

    xfer("sw10", 0, 1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 1'b0, 32'd0);
    xfer("lw10", 0, 1'b0, 32'h10, 3'b010, 32'd0, 1'b0, 32'hDEADBEEF);

    do_reset();
    dual(32'h10, 32'hDEADBEEF, 32'h14, 32'd0, 32'h10, 32'hDEADBEEF);

    xfer("sw80", 0, 1'b1, 32'h10, 3'b010, 32'h80FF0000, 1'b0, 32'd0);
    xfer("lb13", 1, 1'b0, 32'h13, 3'b000, 32'd0, 1'b0, 32'hFFFFFF80);
    xfer("lbu13", 1, 1'b0, 32'h13, 3'b100, 32'd0, 1'b0, 32'h00000080);
    xfer("lh12", 1, 1'b0, 32'h12, 3'b001, 32'd0, 1'b0, 32'hFFFF80FF);

    xfer("lw11", 0, 1'b0, 32'h11, 3'b010, 32'd0, 1'b1, 32'd0);
    xfer("sh03", 0, 1'b1, 32'h03, 3'b001, 32'hFFFF, 1'b1, 32'd0);
    xfer("t011", 0, 1'b0, 32'h10, 3'b011, 32'd0, 1'b1, 32'd0);
    xfer("sw400", 0, 1'b1, 32'h400, 3'b010, 32'h12345678, 1'b1, 32'd0);
    xfer("st101", 1, 1'b1, 32'h10, 3'b101, 32'h00001111, 1'b1, 32'd0);
    chk("mem10_kept", mem[4], 32'h80FF0000);
    chk("mem00_kept", mem[0], 32'd0);
    xfer("lw10b", 1, 1'b0, 32'h10, 3'b010, 32'd0, 1'b0, 32'h80FF0000);
    xfer("sh16", 1, 1'b1, 32'h16, 3'b001, 32'hAAAA1234, 1'b0, 32'd0);
    xfer("lw14", 1, 1'b0, 32'h14, 3'b010, 32'd0, 1'b0, 32'h12340000);

    // Reset during the ACCESS cycle of a p0 load: no ack, rdata cleared.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h10, 3'b010, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("racc_ren", 32'(mem_R_en), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("racc_busy", 32'(busy), 32'd0);
    chk("racc_ack", 32'(p0_ack), 32'd0);
    chk("racc_rdata", p0_rdata, 32'd0);
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    dual(32'h10, 32'h80FF0000, 32'h14, 32'h12340000, 32'h14, 32'h12340000);

    repeat (4) @(negedge clk);
    chk("queues_empty", 32'(q0.size() + q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
